// File: rtl/memory_cache_pkg.sv
// memory_cache_pkg: shared widths, address split and cache line type
package memory_cache_pkg;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 32;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 8;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES    = 2 ** INDEX_W;
    localparam int WORDS    = 2 ** OFFSET_W;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } addr_t;

    typedef struct packed {
        logic                         valid;
        logic [TAG_W-1:0]             tag;
        logic [WORDS-1:0][DATA_W-1:0] data;
    } line_t;

    function automatic addr_t split_addr(input logic [ADDR_W-1:0] a);
        return addr_t'(a);
    endfunction
endpackage

// File: rtl/backing_mem.sv
// backing_mem: read-only 32K x 32 store whose word i holds i, with word and block read ports
module backing_mem
    import memory_cache_pkg::*;
(
    input  logic [ADDR_W-1:0]                addr,
    output logic [DATA_W-1:0]                rd_word,
    input  logic [ADDR_W-OFFSET_W-1:0]       blk_addr,
    output logic [WORDS-1:0][DATA_W-1:0]     rd_blk
);
    assign rd_word = DATA_W'(addr);
    for (genvar i = 0; i < WORDS; i++) begin : g_blk
        assign rd_blk[i] = DATA_W'({blk_addr, OFFSET_W'(i)});
    end
endmodule

// File: rtl/memory_cache.sv
// memory_cache: direct-mapped read-only cache with single-edge block fill on miss
module memory_cache
    import memory_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] Data,
    output logic              hit,
    output logic              miss
);
    addr_t                        f;
    line_t                        cur;
    logic                         match;
    logic [DATA_W-1:0]            mem_word;
    logic [WORDS-1:0][DATA_W-1:0] mem_blk;
    line_t                        lines [LINES] = '{default: '0};

    assign f = split_addr(address);

    backing_mem memory (
        .addr     (address),
        .rd_word  (mem_word),
        .blk_addr ({f.tag, f.index}),
        .rd_blk   (mem_blk)
    );

    assign cur   = lines[f.index];
    assign match = cur.valid && (cur.tag == f.tag);
    assign hit   = match;
    assign miss  = !match;
    // misses forward the backing word so the miss cycle already carries good data
    assign Data  = match ? cur.data[f.offset] : mem_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) lines[i].valid <= 1'b0;
        end else if (!match) begin
            lines[f.index] <= '{valid: 1'b1, tag: f.tag, data: mem_blk};
        end
    end
endmodule

// File: tb/tb_memory_cache.sv
// tb_memory_cache: directed scoreboard bench for memory_cache
module tb_memory_cache;
    import memory_cache_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              h;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] Data;
    logic              hit, miss;
    exp_t              sb [$];
    int                checks = 0, errors = 0, nhit = 0, nmiss = 0;

    always #5 clk = ~clk;

    memory_cache dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .Data    (Data),
        .hit     (hit),
        .miss    (miss)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic access(input int a, input logic h);
        exp_t e;
        @(negedge clk);
        rst     = 1'b0;
        address = ADDR_W'(a);
        sb.push_back('{ADDR_W'(a), DATA_W'(a), h});
        #3;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("data@%0d", e.a), Data, e.d);
            check($sformatf("hit@%0d", e.a), 32'(hit), 32'(e.h));
            check($sformatf("miss@%0d", e.a), 32'(miss), 32'(!e.h));
        end
        if (hit) nhit++;
        if (miss) nmiss++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_onehot", 32'(hit ^ miss), 32'd1);
        check("rst_miss", 32'(miss), 32'd1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("por_onehot", 32'(hit ^ miss), 32'd1);
        check("por_miss", 32'(miss), 32'd1);
        do_reset();

        access(1024, 1'b0);
        access(1025, 1'b1);
        access(1026, 1'b1);
        access(1027, 1'b1);

        access(2048, 1'b0);
        access(1024, 1'b0);

        access(3000, 1'b0);
        access(3000, 1'b1);
        access(3001, 1'b1);

        access(4096, 1'b0);
        access(4097, 1'b1);
        access(4098, 1'b1);
        access(4099, 1'b1);
        do_reset();
        access(4097, 1'b0);

        access(32767, 1'b0);
        access(32764, 1'b1);

        do_reset();
        nhit  = 0;
        nmiss = 0;
        for (int a = 1024; a <= 9215; a++) access(a, (a % 4) != 0);
        check("sweep_misses", 32'(nmiss), 32'd2048);
        check("sweep_hits", 32'(nhit), 32'd6144);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
